// File: rtl/gray_codec_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gray_codec_pipe_pkg
// Brief   : Shared mode encodings and default code width for the Gray codec.
// Revision: 1.0 - initial release
// ============================================================================
package gray_codec_pipe_pkg;
  localparam int   DEFAULT_WIDTH = 4;
  localparam logic MODE_G2B      = 1'b0;
  localparam logic MODE_B2G      = 1'b1;
endpackage
`default_nettype wire

// File: rtl/gray_codec_pipe_conv.sv
`default_nettype none
// ============================================================================
// Module  : gray_conv
// Brief   : Combinational Gray<->binary converter selected by mode.
// Revision: 1.0 - initial release
// ============================================================================
module gray_conv
  import gray_codec_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] w_bin;

  // Binary bit i is the XOR of all Gray bits from i up to the MSB.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign w_bin[i] = ^(data >> i);
  end

  assign result = (mode == MODE_B2G) ? (data ^ (data >> 1)) : w_bin;

endmodule
`default_nettype wire

// File: rtl/gray_codec_pipe.sv
`default_nettype none
// ============================================================================
// Module  : gray_codec_pipe
// Brief   : Two-stage valid/ready Gray codec with optional adjacency checking.
// Revision: 1.0 - initial release
// ============================================================================
module gray_codec_pipe
  import gray_codec_pipe_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit CHECK_ADJ = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             out_adj_err
);

  function automatic int unsigned popcount(input logic [WIDTH-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) n += int'(v[i]);
    return n;
  endfunction

  logic             r_s1_vld;
  logic [WIDTH-1:0] r_s1_data;
  logic             r_s1_mode;
  logic             r_s1_err;
  logic             r_s2_vld;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_mode;
  logic             r_out_err;
  logic [WIDTH-1:0] r_last_gray;
  logic             r_last_gray_vld;

  logic             w_s2_adv;
  logic             w_s1_adv;
  logic             w_in_xfer;
  logic             w_adj_err;
  logic [WIDTH-1:0] w_conv;

  assign w_s2_adv  = !r_s2_vld || out_ready;
  assign w_s1_adv  = !r_s1_vld || w_s2_adv;
  // Gating with rst_n keeps in_ready low for the whole reset window.
  assign in_ready  = rst_n && w_s1_adv;
  assign w_in_xfer = in_valid && in_ready;

  // An identical repeat code has popcount 0 and is flagged like a multi-bit jump.
  assign w_adj_err = CHECK_ADJ && (in_mode == MODE_G2B) && r_last_gray_vld &&
                     (popcount(in_data ^ r_last_gray) != 1);

  gray_conv #(.WIDTH(WIDTH)) u_conv (
    .mode   (r_s1_mode),
    .data   (r_s1_data),
    .result (w_conv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld        <= 1'b0;
      r_s1_data       <= '0;
      r_s1_mode       <= 1'b0;
      r_s1_err        <= 1'b0;
      r_s2_vld        <= 1'b0;
      r_out_data      <= '0;
      r_out_mode      <= 1'b0;
      r_out_err       <= 1'b0;
      r_last_gray     <= '0;
      r_last_gray_vld <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_vld <= w_in_xfer;
      end
      if (w_in_xfer) begin
        r_s1_data <= in_data;
        r_s1_mode <= in_mode;
        r_s1_err  <= w_adj_err;
      end
      // Only Gray-mode words extend the tracked sequence.
      if (w_in_xfer && (in_mode == MODE_G2B)) begin
        r_last_gray     <= in_data;
        r_last_gray_vld <= 1'b1;
      end
      if (w_s2_adv) begin
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld) begin
          r_out_data <= w_conv;
          r_out_mode <= r_s1_mode;
          r_out_err  <= r_s1_err;
        end
      end
    end
  end

  assign out_valid   = r_s2_vld;
  assign out_data    = r_out_data;
  assign out_mode    = r_out_mode;
  assign out_adj_err = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_gray_codec_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_gray_codec_pipe
// Brief   : Self-checking bench for gray_codec_pipe with a reference scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gray_codec_pipe;
  import gray_codec_pipe_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_mode = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_mode;
  logic         out_adj_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gray_codec_pipe #(.WIDTH(W), .CHECK_ADJ(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mode     (in_mode),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_mode    (out_mode),
    .out_adj_err (out_adj_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference decode: find the binary value whose Gray code matches.
  function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
    logic [W-1:0] r;
    r = '0;
    for (int b = 0; b < (1 << W); b++)
      if (W'(b ^ (b >> 1)) == g) r = W'(b);
    return r;
  endfunction

  logic [W+1:0] exp_q[$];
  logic [W-1:0] m_last = '0;
  logic         m_last_vld = 1'b0;
  int           n_in = 0;
  int           n_out = 0;
  int           n_err = 0;
  logic         prev_stall = 1'b0;
  logic [W+1:0] prev_out = '0;
  logic [W+1:0] m_e;
  logic [W-1:0] m_d;
  logic         m_err;

  // Scoreboard: sampled on the falling edge, between active edges.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_last_vld = 1'b0;
      prev_stall = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_in_ready", 32'(in_ready), 32'(0));
    end else begin
      if (prev_stall)
        chk("hold_stable", 32'({out_adj_err, out_mode, out_data}), 32'(prev_out));
      if (out_valid && out_ready) begin
        n_out++;
        if (out_adj_err) n_err++;
        if (exp_q.size() == 0) begin
          chk("spurious_out", 32'(1), 32'(0));
        end else begin
          m_e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(m_e[W-1:0]));
          chk("out_mode", 32'(out_mode), 32'(m_e[W]));
          chk("out_adj_err", 32'(out_adj_err), 32'(m_e[W+1]));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_adj_err, out_mode, out_data};
      if (in_valid && in_ready) begin
        n_in++;
        m_d   = in_mode ? (in_data ^ (in_data >> 1)) : ref_g2b(in_data);
        m_err = 1'b0;
        if (!in_mode) begin
          if (m_last_vld && ($countones(in_data ^ m_last) != 1)) m_err = 1'b1;
          m_last     = in_data;
          m_last_vld = 1'b1;
        end
        exp_q.push_back({m_err, in_mode, m_d});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int  base;
  int  base_in;
  int  cnt;
  int  guard;
  logic acc;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_out_mode", 32'(out_mode), 32'(0));
    chk("rst_out_err", 32'(out_adj_err), 32'(0));
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(in_ready), 32'(1));

    // Gray words back-to-back with fixed latency.
    cyc(); in_valid = 1'b1; in_mode = MODE_G2B; in_data = 4'b0110;
    cyc(); in_data = 4'b1000;
    @(negedge clk);
    chk("lat_not_yet", 32'(out_valid), 32'(0));
    cyc(); in_data = 4'b0000;
    @(negedge clk);
    chk("g2b_a_valid", 32'(out_valid), 32'(1));
    chk("g2b_a_data", 32'(out_data), 32'(4'b0100));
    chk("g2b_a_err", 32'(out_adj_err), 32'(0));
    cyc(); in_valid = 1'b0;
    @(negedge clk);
    chk("g2b_b_data", 32'(out_data), 32'(4'b1111));
    chk("g2b_b_err", 32'(out_adj_err), 32'(1));
    cyc();
    @(negedge clk);
    chk("g2b_c_data", 32'(out_data), 32'(4'b0000));
    chk("g2b_c_err", 32'(out_adj_err), 32'(0));

    // Binary to Gray.
    cyc(); in_valid = 1'b1; in_mode = MODE_B2G; in_data = 4'b0101;
    cyc(); in_data = 4'b1111;
    cyc(); in_valid = 1'b0;
    @(negedge clk);
    chk("b2g_a_data", 32'(out_data), 32'(4'b0111));
    cyc();
    @(negedge clk);
    chk("b2g_b_data", 32'(out_data), 32'(4'b1000));
    chk("b2g_b_mode", 32'(out_mode), 32'(1));

    // Full Gray cycle with wrap, from a fresh reset.
    do_reset();
    base = n_out;
    cnt  = n_err;
    for (int k = 0; k <= 16; k++) begin
      cyc(); in_valid = 1'b1; in_mode = MODE_G2B; in_data = W'((k % 16) ^ ((k % 16) >> 1));
    end
    cyc(); in_valid = 1'b0;
    repeat (4) cyc();
    chk("seq_count", 32'(n_out - base), 32'(17));
    chk("seq_errs", 32'(n_err - cnt), 32'(0));

    // Back-pressure: two words fill the pipe, then in_ready drops.
    base_in = n_in;
    cyc(); out_ready = 1'b0; in_valid = 1'b1; in_mode = MODE_B2G; in_data = 4'h3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), (i < 2) ? 32'(1) : 32'(0));
      cyc();
      if (i == 0) in_data = 4'h9;
      if (i == 1) in_data = 4'hC;
    end
    out_ready = 1'b1;
    cyc(); in_valid = 1'b0;
    repeat (5) cyc();
    chk("bp_in_count", 32'(n_in - base_in), 32'(3));
    chk("bp_drained", 32'(exp_q.size()), 32'(0));

    // Random valid/ready traffic.
    cnt = 0; guard = 0; acc = 1'b0; in_valid = 1'b0;
    while (cnt < 1000 && guard < 20000) begin
      cyc();
      if (!in_valid || acc) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = W'($urandom);
        in_mode  = 1'($urandom_range(0, 1));
      end
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) cnt++;
      guard++;
    end
    chk("rand_words", 32'(cnt), 32'(1000));
    cyc(); in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) cyc();
    chk("rand_drained", 32'(exp_q.size()), 32'(0));
    chk("rand_in_eq_out", 32'(n_in), 32'(n_out));

    // Reset with two words in flight.
    cyc(); out_ready = 1'b0; in_valid = 1'b1; in_mode = MODE_G2B; in_data = 4'h5;
    cyc(); in_data = 4'h7;
    cyc(); in_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("rst_flush_valid", 32'(out_valid), 32'(0));
    base = n_out;
    cyc();
    cyc();
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (4) cyc();
    chk("no_stale", 32'(n_out - base), 32'(0));
    in_valid = 1'b1; in_mode = MODE_G2B; in_data = 4'hA;
    cyc(); in_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'(1));
    chk("post_rst_data", 32'(out_data), 32'(4'hC));
    chk("post_rst_err", 32'(out_adj_err), 32'(0));
    repeat (3) cyc();
    chk("final_drained", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
